// File: rtl/fir_poly_combine.sv
// fir_poly_combine: sums snapshotted bank results, scales/saturates, queues into a 2-entry FIFO
// Define FIR_COMBINE_ROUND_EN for round-half-up scaling; default build truncates.
module fir_poly_combine #(
    parameter int N_BANKS   = 4,
    parameter int BANK_LOG2 = 2,
    parameter int IN_WIDTH  = 35,
    parameter int ACC_WIDTH = 37,
    parameter int SHIFT     = 10,
    parameter int OUT_WIDTH = 25
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        frame_end,
    input  logic [N_BANKS*IN_WIDTH-1:0] bank_din,
    output logic [OUT_WIDTH-1:0]        dout,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic                        busy,
    output logic                        sat,
    output logic                        overlap,
    output logic                        overrun
);
    typedef enum logic [1:0] {IDLE, SUM, SCALE, PUSH} state_t;
    localparam logic signed [ACC_WIDTH-1:0] MAXV = ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] MINV = -MAXV - ACC_WIDTH'(1);
    state_t state, state_nx;
    logic [IN_WIDTH-1:0] cap [N_BANKS];
    logic [BANK_LOG2-1:0] idx;
    logic signed [ACC_WIDTH-1:0] acc, scaled;
    logic [OUT_WIDTH-1:0] hold, sample, mem1;
    logic [1:0] cnt;
    logic hi, lo, pop, push, last;
    assign last = idx == BANK_LOG2'(N_BANKS - 1);
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = frame_end ? SUM : IDLE;
            SUM:   state_nx = last ? SCALE : SUM;
            SCALE: state_nx = PUSH;
            PUSH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
`ifdef FIR_COMBINE_ROUND_EN
    localparam logic signed [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(1) << (SHIFT - 1);
    always_comb scaled = (acc + HALF) >>> SHIFT;
`else
    always_comb scaled = acc >>> SHIFT;
`endif
    always_comb begin
        hi = scaled > MAXV;
        lo = scaled < MINV;
        sample = hi ? MAXV[OUT_WIDTH-1:0] : lo ? MINV[OUT_WIDTH-1:0] : scaled[OUT_WIDTH-1:0];
    end
    assign busy       = state != IDLE;
    assign dout_valid = cnt != 2'd0;
    assign pop        = dout_valid && dout_ready;
    assign push       = state == PUSH && (cnt != 2'd2 || pop);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            acc     <= '0;
            hold    <= '0;
            sat     <= 1'b0;
            overlap <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && frame_end) begin
                for (int k = 0; k < N_BANKS; k++) cap[k] <= bank_din[k*IN_WIDTH +: IN_WIDTH];
                acc <= '0;
                idx <= '0;
            end
            if (state != IDLE && frame_end) overlap <= 1'b1;
            if (state == SUM) begin
                acc <= acc + {{(ACC_WIDTH - IN_WIDTH){cap[idx][IN_WIDTH-1]}}, cap[idx]};
                idx <= idx + 1'b1;
            end
            if (state == SCALE) begin
                hold <= sample;
                if (hi || lo) sat <= 1'b1;
            end
            if (state == PUSH && !push) overrun <= 1'b1;
        end
    end
    // Head register drives dout directly, so it only moves on a pop or a write into an empty FIFO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            dout <= '0;
            mem1 <= '0;
        end else if (push && pop) begin
            dout <= cnt == 2'd2 ? mem1 : hold;
            if (cnt == 2'd2) mem1 <= hold;
        end else if (pop) begin
            dout <= mem1;
            cnt  <= cnt - 2'd1;
        end else if (push) begin
            if (cnt == 2'd0) dout <= hold;
            else mem1 <= hold;
            cnt <= cnt + 2'd1;
        end
    end
endmodule

// File: tb/tb_fir_poly_combine.sv
// tb_fir_poly_combine: directed checks of sum/scale/saturate, overlap, overrun and reset abort
module tb_fir_poly_combine;
    logic clk = 1'b0, rst_n = 1'b0, frame_end = 1'b0, dout_ready = 1'b0;
    logic [139:0] bank_din = '0;
    logic signed [24:0] dout;
    logic dout_valid, busy, sat, overlap, overrun;
    int ncmp = 0, nerr = 0, nval;
`ifdef FIR_COMBINE_ROUND_EN
    localparam longint EA = 3, EB = 0;
`else
    localparam longint EA = 2, EB = -1;
`endif
    localparam longint P33 = 64'sd8589934592, N34 = -64'sd17179869184;
    always #5 clk = ~clk;
    fir_poly_combine dut (
        .clk(clk), .rst_n(rst_n), .frame_end(frame_end), .bank_din(bank_din),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .sat(sat), .overlap(overlap), .overrun(overrun)
    );
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic strobe(input longint b0, input longint b1, input longint b2, input longint b3);
        bank_din  = {b3[34:0], b2[34:0], b1[34:0], b0[34:0]};
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_dout"}, dout, 0);
        chk({tag, "_valid"}, {63'd0, dout_valid}, 0);
        chk({tag, "_busy"}, {63'd0, busy}, 0);
        chk({tag, "_sat"}, {63'd0, sat}, 0);
        chk({tag, "_overlap"}, {63'd0, overlap}, 0);
        chk({tag, "_overrun"}, {63'd0, overrun}, 0);
    endtask
    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        chk_reset("rst");
        rst_n = 1'b1;
        dout_ready = 1'b1;
        strobe(1024, 2048, -512, 0);
        chk("t1_busy_T1", {63'd0, busy}, 1);
        chk("t1_valid_T1", {63'd0, dout_valid}, 0);
        for (int i = 2; i <= 6; i++) begin
            tick();
            chk($sformatf("t1_valid_T%0d", i), {63'd0, dout_valid}, 0);
        end
        chk("t1_busy_T6", {63'd0, busy}, 1);
        tick();
        chk("t1_valid_T7", {63'd0, dout_valid}, 1);
        chk("t1_dout", dout, EA);
        chk("t1_busy_T7", {63'd0, busy}, 0);
        chk("t1_sat", {63'd0, sat}, 0);
        tick();
        chk("t1_popped", {63'd0, dout_valid}, 0);
        strobe(-1, -1, -1, -1);
        repeat (6) tick();
        chk("t2_valid", {63'd0, dout_valid}, 1);
        chk("t2_dout", dout, EB);
        chk("t2_sat", {63'd0, sat}, 0);
        tick();
        strobe(P33, P33, P33, P33);
        repeat (6) tick();
        chk("t3_dout", dout, 16777215);
        chk("t3_sat", {63'd0, sat}, 1);
        tick();
        strobe(N34, N34, N34, N34);
        repeat (6) tick();
        chk("t4_valid", {63'd0, dout_valid}, 1);
        chk("t4_dout", dout, -16777216);
        tick();
        do_reset();
        strobe(1024, 2048, -512, 0);
        tick();
        tick();
        strobe(P33, P33, P33, P33);
        chk("ov_flag", {63'd0, overlap}, 1);
        chk("ov_busy", {63'd0, busy}, 1);
        repeat (3) tick();
        chk("ov_valid", {63'd0, dout_valid}, 1);
        chk("ov_dout", dout, EA);
        nval = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            nval += int'(dout_valid);
        end
        chk("ov_extra", nval, 0);
        chk("ov_sat", {63'd0, sat}, 0);
        do_reset();
        dout_ready = 1'b0;
        strobe(1024, 2048, -512, 0);
        repeat (19) tick();
        chk("or_first", dout, EA);
        strobe(-1, -1, -1, -1);
        for (int i = 0; i < 19; i++) begin
            tick();
            chk("or_stable", dout, EA);
        end
        strobe(P33, P33, P33, P33);
        repeat (19) tick();
        chk("or_flag", {63'd0, overrun}, 1);
        chk("or_head", dout, EA);
        chk("or_valid", {63'd0, dout_valid}, 1);
        dout_ready = 1'b1;
        tick();
        chk("or_second", dout, EB);
        chk("or_second_valid", {63'd0, dout_valid}, 1);
        tick();
        chk("or_empty", {63'd0, dout_valid}, 0);
        do_reset();
        dout_ready = 1'b0;
        strobe(1024, 2048, -512, 0);
        repeat (7) tick();
        chk("ab_queued", {63'd0, dout_valid}, 1);
        strobe(-1, -1, -1, -1);
        tick();
        chk("ab_in_sum", {63'd0, busy}, 1);
        rst_n = 1'b0;
        tick();
        chk_reset("ab");
        rst_n = 1'b1;
        dout_ready = 1'b1;
        nval = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            nval += int'(dout_valid);
        end
        chk("ab_no_output", nval, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/fir_poly_combine.md
# fir_poly_combine

Output stage of the polyphase decimating FIR, directly downstream of the per-phase bank accumulators. On each frame strobe it snapshots all bank results and sums them sequentially. It then scales and saturates the sum to the output width. Each result goes into a 2-entry output FIFO with a valid/ready handshake. Sticky flags report saturation, frame overlap and FIFO overrun.

## Interface
- N_BANKS, 4, number of bank outputs summed per frame
- BANK_LOG2, 2, bits for a bank index counter (ceil(log2(N_BANKS)))
- IN_WIDTH, 35, signed width of each bank result
- ACC_WIDTH, 37, sum width (IN_WIDTH + BANK_LOG2)
- SHIFT, 10, LSBs dropped by scaling (arithmetic shift right, SHIFT ≥ 1)
- OUT_WIDTH, 25, signed output width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- frame_end  in  1  single-cycle strobe; all bank results are final in this cycle
- bank_din  in  N_BANKS*IN_WIDTH  packed signed bank results, bank k at bits [k*IN_WIDTH +: IN_WIDTH]
- dout  out  OUT_WIDTH  signed decimated sample at FIFO head
- dout_valid  out  1  FIFO head valid
- dout_ready  in  1  consumer accepts head when dout_valid && dout_ready
- busy  out  1  high in every state except IDLE
- sat  out  1  sticky: a sample was saturated
- overlap  out  1  sticky: frame_end arrived while busy
- overrun  out  1  sticky: a result was dropped because the FIFO was full

## Operation
- Reset values: dout=0, dout_valid=0, busy=0, sat=0, overlap=0, overrun=0. The FSM goes to IDLE, the FIFO is emptied and the accumulator is cleared. Sticky flags clear only on reset.
- Reset mid-operation discards any in-flight sum and all FIFO contents. No output is produced for that frame.
- FSM states and transitions:
  - IDLE: on frame_end, load all N_BANKS values into the capture registers, clear the accumulator, set index=0, go to SUM.
  - SUM: each cycle, acc <= acc + sign-extend(capture[index]) and index increments. After the add of index N_BANKS-1, go to SCALE.
  - SCALE: compute the scaled, saturated sample into a holding register. Go to PUSH.
  - PUSH: write the holding register to the FIFO. Go to IDLE.
- frame_end in any state other than IDLE is ignored and sets overlap. The capture registers are not disturbed.
- Arithmetic:
  - All operations are signed two's complement. The accumulator is ACC_WIDTH bits and cannot overflow for N_BANKS ≤ 2^BANK_LOG2.
  - scaled = acc >>> SHIFT, computed in ACC_WIDTH bits.
  - Saturation: if scaled > 2^(OUT_WIDTH-1)-1, output that maximum. If scaled < -2^(OUT_WIDTH-1), output that minimum. In either case set sat. Otherwise output scaled[OUT_WIDTH-1:0].
- FIFO rules:
  - 2 entries; dout is driven from the head register.
  - A pop occurs when dout_valid && dout_ready.
  - In PUSH, the write is accepted if fewer than 2 entries are held, or if a pop happens in the same cycle.
  - Otherwise the new sample is dropped, overrun is set, and the FIFO contents are unchanged.
  - Simultaneous push and pop on an empty FIFO is impossible, because dout_valid=0 when empty.
  - dout must be held stable while dout_valid=1 and dout_ready=0.

## Timing
- With frame_end sampled in IDLE at cycle T:
  - Capture registers are valid at T+1.
  - SUM occupies T+1..T+N_BANKS.
  - SCALE is at T+N_BANKS+1.
  - PUSH is at T+N_BANKS+2.
- With an empty FIFO, dout_valid rises at T+N_BANKS+3. Latency is N_BANKS+3 cycles (7 by default).
- busy is high from T+1 through T+N_BANKS+2.
- The earliest frame_end that is not an overlap is at T+N_BANKS+3. Frame period (the decimation factor M) must be ≥ N_BANKS+3.
- A pop takes effect at the clock edge. The next entry appears on dout in the following cycle.
- The FIFO sustains one pop per cycle.

## Configuration
- FIR_COMBINE_ROUND_EN:
  - Defined: in SCALE, 2^(SHIFT-1) is added to acc before the shift, giving round-half-up. Saturation is applied after rounding.
  - Undefined: plain truncation toward negative infinity, with no adder.
  - Latency is identical in both builds.

## Test plan
- Banks {1024, 2048, -512, 0}, one frame_end, dout_ready=1 -> dout=2 (truncate) or 3 (round), valid exactly 7 cycles after the strobe, sat=0.
- Banks all -1 -> dout=-1 (truncate) or 0 (round).
- Banks all 2^33 -> dout=16777215, sat=1. Banks all -2^34 -> dout=-16777216.
- frame_end repeated 3 cycles after the first -> only the first result is emitted, overlap=1, result unaffected by the second strobe's bank values.
- dout_ready=0, three frames spaced 20 cycles -> first two results held in order and stable, third dropped, overrun=1. Raising ready then yields the two held samples on consecutive cycles.
- Assert rst_n=0 during SUM with one sample queued -> next cycle all outputs at reset values, FIFO empty, no sample emitted for the aborted frame.
